// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU responder.
//   WIDTH_DEF  default operand/result width
//   OP_*       3-bit opcode encodings (same as the combinational ALU)
//   state_t    responder FSM states
package alu_seq_pkg;

   localparam int WIDTH_DEF = 16;

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_AND = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_step.sv
// alu_seq_step: combinational single-bit rotate/shift step.
//   op   [1:0]  00 rotate left, 01 shift left logical,
//               10 shift right arithmetic, 11 shift right logical
//   din  [W]    value before the step
//   dout [W]    value after one bit of movement
module alu_seq_step
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      case (op)
         2'b00:   dout = {din[WIDTH-2:0], din[WIDTH-1]};
         2'b01:   dout = {din[WIDTH-2:0], 1'b0};
         2'b10:   dout = {din[WIDTH-1], din[WIDTH-1:1]};
         default: dout = {1'b0, din[WIDTH-1:1]};
      endcase
   end

endmodule

// File: rtl/alu_seq_resp.sv
// alu_seq_resp: sequential ALU responder with valid/ready request and
// response handshakes. Add/sub/xor/and complete in one cycle; shifts and
// rotates move one bit per cycle unless ALU_SEQ_FAST_SHIFT_EN is defined,
// in which case a 4-stage barrel shifter gives every op the 1-cycle path.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake
//   A, B, Op, Cin            operands (pre-inversion), opcode, carry-in
//   invA, invB, sign         operand inversion, signed-overflow select
//   rsp_valid / rsp_ready    response handshake
//   Out, Ofl, Z, N           registered result and flags
module alu_seq_resp
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Op,
   input  logic             Cin,
   input  logic             invA,
   input  logic             invB,
   input  logic             sign,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] Out,
   output logic             Ofl,
   output logic             Z,
   output logic             N
);

   state_t           state;
   logic [WIDTH-1:0] a_in, b_in, addend, imm_out;
   logic [WIDTH:0]   sum;
   logic [3:0]       k_in;
   logic             req_fire, carry_in, c_top, c_msb, imm_ofl;

   assign a_in      = invA ? ~A : A;
   assign b_in      = invB ? ~B : B;
   assign k_in      = b_in[3:0];
   assign req_ready = (state == IDLE) & ~rst;
   assign req_fire  = req_valid & req_ready;

   // Subtract is a + ~b + 1 so Ofl with sign=0 reads as "no borrow".
   assign addend   = (Op == OP_SUB) ? ~b_in : b_in;
   assign carry_in = (Op == OP_SUB) ? 1'b1 : Cin;
   assign sum      = {1'b0, a_in} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};
   assign c_top    = sum[WIDTH];
   // Carry into the MSB recovered from the MSB sum bit.
   assign c_msb    = a_in[WIDTH-1] ^ addend[WIDTH-1] ^ sum[WIDTH-1];

`ifdef ALU_SEQ_FAST_SHIFT_EN
   logic [WIDTH-1:0] sh_fast;

   // Cascade of shift-by-2^i stages, each enabled by bit i of k.
   always_comb begin
      sh_fast = a_in;
      for (int i = 0; i < 4; i++) begin
         if (k_in[i]) begin
            case (Op[1:0])
               2'b00:   sh_fast = (sh_fast << (1 << i)) | (sh_fast >> (WIDTH - (1 << i)));
               2'b01:   sh_fast = sh_fast << (1 << i);
               2'b10:   sh_fast = $signed(sh_fast) >>> (1 << i);
               default: sh_fast = sh_fast >> (1 << i);
            endcase
         end
      end
   end
`else
   logic [WIDTH-1:0] work_q, step_out;
   logic [1:0]       op_q;
   logic [3:0]       count;

   alu_seq_step #(.WIDTH(WIDTH)) u_step (
      .op   (op_q),
      .din  (work_q),
      .dout (step_out)
   );
`endif

   // Result for everything that completes straight from IDLE.
   always_comb begin
      imm_out = '0;
      imm_ofl = 1'b0;
      case (Op)
         OP_ADD, OP_SUB: begin
            imm_out = sum[WIDTH-1:0];
            imm_ofl = sign ? (c_top ^ c_msb) : c_top;
         end
         OP_XOR: imm_out = a_in ^ b_in;
         OP_AND: imm_out = a_in & b_in;
`ifdef ALU_SEQ_FAST_SHIFT_EN
         default: imm_out = sh_fast;
`else
         // Only reached for k = 0 shifts: value passes through unchanged.
         default: imm_out = a_in;
`endif
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         Out       <= '0;
         Ofl       <= 1'b0;
         Z         <= 1'b0;
         N         <= 1'b0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
         count     <= '0;
         work_q    <= '0;
         op_q      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
`ifndef ALU_SEQ_FAST_SHIFT_EN
                  if (!Op[2] && k_in != 4'd0) begin
                     state  <= SHIFT;
                     count  <= k_in;
                     work_q <= a_in;
                     op_q   <= Op[1:0];
                  end else
`endif
                  begin
                     state     <= DONE;
                     rsp_valid <= 1'b1;
                     Out       <= imm_out;
                     Ofl       <= imm_ofl;
                     Z         <= (imm_out == '0);
                     N         <= imm_out[WIDTH-1];
                  end
               end
            end
`ifndef ALU_SEQ_FAST_SHIFT_EN
            SHIFT: begin
               work_q <= step_out;
               count  <= count - 4'd1;
               if (count == 4'd1) begin
                  state     <= DONE;
                  rsp_valid <= 1'b1;
                  Out       <= step_out;
                  Ofl       <= 1'b0;
                  Z         <= (step_out == '0);
                  N         <= step_out[WIDTH-1];
               end
            end
`endif
            DONE: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_resp.sv
// tb_alu_seq_resp: self-checking bench for alu_seq_resp. A behavioural model
// computes result, flags and latency per request; a compare process checks
// outputs every cycle against the expected-response queue. Honours
// ALU_SEQ_FAST_SHIFT_EN for expected latency.
module tb_alu_seq_resp;
   import alu_seq_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready, rsp_valid, rsp_ready;
   logic [W-1:0] A, B, Out;
   logic [2:0]   Op;
   logic         Cin, invA, invB, sign, Ofl, Z, N;

   alu_seq_resp #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .A(A), .B(B), .Op(Op), .Cin(Cin), .invA(invA), .invB(invB), .sign(sign),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .Out(Out), .Ofl(Ofl), .Z(Z), .N(N)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] out;
      logic         ofl;
      logic         z;
      logic         n;
      int           lat;
   } exp_t;

   exp_t         exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           last_lat = 0;
   logic [W-1:0] last_out = '0;
   logic         last_ofl = 1'b0, last_z = 1'b0, last_n = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a0, input logic [W-1:0] b0,
                                  input logic [2:0] op, input logic ci, input logic ia,
                                  input logic ib, input logic sg);
      exp_t         e;
      logic [W-1:0] a, b, r;
      logic [31:0]  dbl;
      int           k, ua, ub, sa, sb, tot, stot;
      logic         c16, sovf;
      a = ia ? ~a0 : a0;
      b = ib ? ~b0 : b0;
      k = int'(b[3:0]);
      ua = int'(a); ub = int'(b);
      sa = $signed(a); sb = $signed(b);
      c16 = 1'b0; sovf = 1'b0; r = '0;
      case (op)
         OP_ROL: begin dbl = {a, a}; dbl = dbl << k; r = dbl[31:16]; end
         OP_SLL: r = a << k;
         OP_SRA: r = $signed(a) >>> k;
         OP_SRL: r = a >> k;
         OP_ADD: begin
            tot = ua + ub + int'(ci); r = tot[15:0]; c16 = (tot > 65535);
            stot = sa + sb + int'(ci); sovf = (stot > 32767) || (stot < -32768);
         end
         OP_SUB: begin
            tot = ua - ub; r = tot[15:0]; c16 = (ua >= ub);
            stot = sa - sb; sovf = (stot > 32767) || (stot < -32768);
         end
         OP_XOR: r = a ^ b;
         default: r = a & b;
      endcase
      e.out = r;
      e.ofl = (op == OP_ADD || op == OP_SUB) ? (sg ? sovf : c16) : 1'b0;
      e.z   = (r == 0);
      e.n   = r[15];
`ifdef ALU_SEQ_FAST_SHIFT_EN
      e.lat = 1;
`else
      e.lat = (op[2] || k == 0) ? 1 : 1 + k;
`endif
      return e;
   endfunction

   // Compare process: response contents while valid, hold of last result otherwise.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         last_out = '0; last_ofl = 1'b0; last_z = 1'b0; last_n = 1'b0;
      end else if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 want 0 at %0t", $time);
         end else begin
            check("rsp_out", Out, exp_q[0].out);
            check("rsp_ofl", Ofl, exp_q[0].ofl);
            check("rsp_z",   Z,   exp_q[0].z);
            check("rsp_n",   N,   exp_q[0].n);
            if (rsp_ready) begin
               last_out = exp_q[0].out; last_ofl = exp_q[0].ofl;
               last_z = exp_q[0].z; last_n = exp_q[0].n;
               void'(exp_q.pop_front());
            end
         end
      end else begin
         check("hold_out", Out, last_out);
         check("hold_flags", {Ofl, Z, N}, {last_ofl, last_z, last_n});
      end
   end

   task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic ci, input logic ia, input logic ib, input logic sg,
                         input int hold, input bit poke);
      exp_t e;
      int   lat;
      e = model(a, b, op, ci, ia, ib, sg);
      lat = 0;
      while (!req_ready && lat < 40) begin @(posedge clk); #1; lat++; end
      check("req_ready_wait", req_ready, 1'b1);
      A = a; B = b; Op = op; Cin = ci; invA = ia; invB = ib; sign = sg;
      req_valid = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      A = $urandom; B = $urandom;   // must be ignored after capture
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         check("ready_busy", req_ready, 1'b0);
         @(posedge clk); #1; lat++;
      end
      last_lat = lat;
      check("latency", lat, e.lat);
      for (int i = 0; i < hold; i++) begin
         if (poke && i == hold / 2) begin
            A = $urandom; B = $urandom; Op = OP_ADD; req_valid = 1'b1;
         end
         @(posedge clk); #1;
         req_valid = 1'b0;
         check("ready_in_done", req_ready, 1'b0);
         check("valid_held", rsp_valid, 1'b1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("valid_drop", rsp_valid, 1'b0);
      check("ready_back", req_ready, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      A = '0; B = '0; Op = '0; Cin = 1'b0; invA = 1'b0; invB = 1'b0; sign = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", req_ready, 1'b0);
      check("rst_valid", rsp_valid, 1'b0);
      check("rst_out", {Out, Ofl, Z, N}, 19'h0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", req_ready, 1'b1);

      // Directed cases with hand-computed results.
      do_txn(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      check("add_s_lit", {Out, Ofl, N, Z}, {16'h8000, 1'b1, 1'b1, 1'b0});
      check("add_lat_lit", last_lat, 1);
      do_txn(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("add_u_lit", {Out, Ofl}, {16'h8000, 1'b0});
      do_txn(16'h1234, 16'h1234, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
      check("sub_lit", {Out, Z, Ofl}, {16'h0000, 1'b1, 1'b1});
      do_txn(16'h8001, 16'h0004, OP_SRA, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("sra_lit", Out, 16'hF800);
`ifdef ALU_SEQ_FAST_SHIFT_EN
      check("sra_lat_lit", last_lat, 1);
`else
      check("sra_lat_lit", last_lat, 5);
`endif
      do_txn(16'h8001, 16'h0001, OP_ROL, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("rol_lit", Out, 16'h0003);
      do_txn(16'h8001, 16'h0010, OP_ROL, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("rol_k0_lit", Out, 16'h8001);
      check("rol_k0_lat_lit", last_lat, 1);
      do_txn(16'h8000, 16'h000F, OP_SRL, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("srl15_lit", Out, 16'h0001);
`ifndef ALU_SEQ_FAST_SHIFT_EN
      check("srl15_lat_lit", last_lat, 16);
`endif
      do_txn(16'h0001, 16'h000F, OP_SLL, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("sll15_lit", {Out, N}, {16'h8000, 1'b1});
      do_txn(16'hFF00, 16'h0FF0, OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b1);
      check("xor_bp_lit", {Out, N, Z}, {16'hF0F0, 1'b1, 1'b0});

      // Reset during a k = 9 rotate drops the transaction.
      A = 16'h1234; B = 16'h0009; Op = OP_ROL; Cin = 1'b0; invA = 1'b0; invB = 1'b0;
      sign = 1'b0; req_valid = 1'b1;
      exp_q.push_back(model(16'h1234, 16'h0009, OP_ROL, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("ready_in_rst", req_ready, 1'b0);
      check("valid_in_rst", rsp_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("ready_post_rst", req_ready, 1'b1);
      check("out_post_rst", Out, 16'h0000);
      seen = 1'b0;
      repeat (20) begin @(posedge clk); #1; seen |= rsp_valid; end
      check("no_rsp_after_rst", seen, 1'b0);

      // Randomized traffic.
      for (int t = 0; t < 300; t++) begin
         logic [2:0] rop;
         rop = 3'($urandom_range(0, 7));
         do_txn(16'($urandom), 16'($urandom), rop, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
      end

      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
